quiz_input_conditioner: RTL and testbench
=========================================

Name: quiz_input_conditioner

Overview:
Upstream input stage for the arithmetic quiz game core. It takes the raw answer switches and the "set" (new question) button. It synchronises and debounces them, then turns them into clean single-cycle events: a set pulse, an answer-accepted pulse with a 2-bit operator code, and a multi-press error pulse. The game core consumes these events instead of sampling raw levels, so a held or bouncing switch scores exactly once.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from its debounced level before that level changes; legal range 1 or more.
- CNT_W, derived as clog2(DEBOUNCE_CYCLES+1), debounce counter width; not overridable.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- switch, input, 4: raw answer switches; bit 0 = +, 1 = -, 2 = *, 3 = /.
- set, input, 1: raw "new question" button.
- set_pulse, output, 1: one-cycle pulse on the debounced rising edge of set.
- ans_valid, output, 1: one-cycle pulse when exactly one answer switch is newly pressed.
- ans_code, output, 2: index of the accepted switch; holds until the next accept.
- multi_err, output, 1: one-cycle pulse when more than one answer switch is pressed simultaneously from idle.
- sw_stable, output, 4: debounced switch levels, for display and debug.

Behaviour:
- Reset (reset==0, asynchronous): every register clears.
  - Synchroniser flops, debounce counters and debounced levels go to 0; FSM goes to IDLE.
  - Outputs: set_pulse=0, ans_valid=0, ans_code=0, multi_err=0, sw_stable=0.
- Synchroniser: two-flop synchroniser per raw bit (5 bits).
- Debounce, per bit, independently:
  - If synced != stable: the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and synced still differs: stable takes synced and the counter clears.
  - Any cycle with synced == stable clears the counter.
  - Latency from a raw change to the stable change: 2+DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles never reaches stable.
- set_pulse: registered. It goes high for exactly one cycle on the edge after stable_set goes 0 to 1. It ignores the answer FSM completely.
- Answer FSM (registered; the decision is made on sw_stable).
  - IDLE:
    - sw_stable==0: stay in IDLE.
    - Exactly one bit set: ans_valid=1 for one cycle, ans_code=bit index, go to HELD.
    - Two or more bits set: multi_err=1 for one cycle, ans_code unchanged, go to LOCK.
  - HELD: no pulses. Additional switches pressed while in HELD are ignored. When sw_stable==0, go to IDLE.
  - LOCK: same as HELD, but entered only after an error.
- Switches whose debounced levels rise on different cycles are not simultaneous. The first one is accepted and later ones are ignored until all switches are released.
- ans_valid and multi_err are mutually exclusive. Either may coincide with set_pulse.
- Reset mid-operation: the FSM returns to IDLE and stable clears. A switch still held when reset deasserts re-debounces and is accepted 2+DEBOUNCE_CYCLES+1 edges after reset release.

Test Plan:
- DEBOUNCE_CYCLES=4, reset deasserted, raw switch[2] 0->1 and held -> sw_stable[2]=1 on edge 6; ans_valid=1 for only the cycle after edge 7; ans_code=2; no further pulses while held.
- switch[0] pulsed high for 3 cycles (synced glitch shorter than 4) -> sw_stable stays 0, ans_valid never asserts.
- switch[1] and switch[3] raised on the same cycle -> multi_err=1 for one cycle, ans_valid=0, ans_code keeps its previous value. Release both, then press switch[3] -> ans_valid pulse, ans_code=3.
- switch[0] accepted and held, then switch[1] pressed and released, then all released, then switch[1] pressed -> exactly one ans_valid (code 0) during the hold, then one ans_valid (code 1) after the release.
- set raw 0->1 while switch[2] also rises on the same cycle -> set_pulse and ans_valid both asserted on edge 7; set held for 50 cycles -> only one set_pulse.
- reset driven low while in HELD with switch[1] held, then released -> all outputs 0 during reset; after release, ans_valid with ans_code=1 on edge 7 after reset deassertion.

Source files
------------

// File: rtl/quiz_input_conditioner.sv
// Input conditioner for the arithmetic quiz core: synchronises and debounces the
// answer switches and set button, then emits single-cycle set/answer/error events.
module quiz_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] switch,
    input  logic       set,
    output logic       set_pulse,
    output logic       ans_valid,
    output logic [1:0] ans_code,
    output logic       multi_err,
    output logic [3:0] sw_stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned NBITS = 5;
    localparam int unsigned SET_BIT = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    logic [NBITS-1:0]            raw;
    logic [NBITS-1:0]            sync_q1;
    logic [NBITS-1:0]            sync_q2;
    logic [NBITS-1:0][CNT_W-1:0] cnt_q;
    logic [NBITS-1:0][CNT_W-1:0] cnt_d;
    logic [NBITS-1:0]            stable_q;
    logic [NBITS-1:0]            stable_d;
    logic                        stable_set_q;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       ans_valid_d;
    logic       multi_err_d;
    logic [1:0] ans_code_d;
    logic [3:0] sw_lvl;
    logic       sw_multi;

    assign raw = {set, switch};

    // Lowest set bit index; only meaningful when exactly one bit is set.
    function automatic logic [1:0] sw_index(input logic [3:0] sw);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (sw[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Two-flop synchroniser on every raw bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // Per-bit debounce: level changes only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < int'(NBITS); i++) begin
            if (sync_q2[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync_q2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign sw_stable = stable_q[3:0];

    // Set edge detector runs independently of the answer FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_set_q <= 1'b0;
            set_pulse    <= 1'b0;
        end else begin
            stable_set_q <= stable_q[SET_BIT];
            set_pulse    <= stable_q[SET_BIT] & ~stable_set_q;
        end
    end

    assign sw_lvl   = stable_q[3:0];
    assign sw_multi = |(sw_lvl & (sw_lvl - 4'd1));

    // Answer FSM: only a press out of the all-released state is scored.
    always_comb begin
        state_d     = state_q;
        ans_valid_d = 1'b0;
        multi_err_d = 1'b0;
        ans_code_d  = ans_code;
        case (state_q)
            ST_IDLE: begin
                if (sw_lvl != 4'd0) begin
                    if (sw_multi) begin
                        multi_err_d = 1'b1;
                        state_d     = ST_LOCK;
                    end else begin
                        ans_valid_d = 1'b1;
                        ans_code_d  = sw_index(sw_lvl);
                        state_d     = ST_HELD;
                    end
                end
            end
            ST_HELD, ST_LOCK: begin
                if (sw_lvl == 4'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ans_valid <= 1'b0;
            multi_err <= 1'b0;
            ans_code  <= 2'd0;
        end else begin
            state_q   <= state_d;
            ans_valid <= ans_valid_d;
            multi_err <= multi_err_d;
            ans_code  <= ans_code_d;
        end
    end

endmodule

// File: tb/tb_quiz_input_conditioner.sv
// Bench for quiz_input_conditioner: sliding-window debounce model plus event model,
// checked every cycle, with directed literal checks and randomized stimulus.
module tb_quiz_input_conditioner;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] switch = 4'd0;
    logic       set = 1'b0;
    logic       set_pulse;
    logic       ans_valid;
    logic [1:0] ans_code;
    logic       multi_err;
    logic [3:0] sw_stable;

    quiz_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .switch    (switch),
        .set       (set),
        .set_pulse (set_pulse),
        .ans_valid (ans_valid),
        .ans_code  (ans_code),
        .multi_err (multi_err),
        .sw_stable (sw_stable)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;
    int n_valid = 0;
    int n_err = 0;
    int n_set = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw history window, debounced levels, and event rules.
    logic [4:0] hist [D+2];
    logic [4:0] m_stable;
    logic       m_set_prev;
    logic       m_busy;
    logic       m_set_pulse;
    logic       m_valid;
    logic       m_err;
    logic [1:0] m_code;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < int'(D) + 2; j++) hist[j] = 5'd0;
            m_stable    = 5'd0;
            m_set_prev  = 1'b0;
            m_busy      = 1'b0;
            m_set_pulse = 1'b0;
            m_valid     = 1'b0;
            m_err       = 1'b0;
            m_code      = 2'd0;
        end else begin
            // Events are decided on the debounced levels held before this edge.
            m_set_pulse = m_stable[4] && !m_set_prev;
            m_set_prev  = m_stable[4];
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (!m_busy) begin
                if ($countones(m_stable[3:0]) == 1) begin
                    m_valid = 1'b1;
                    for (int b = 0; b < 4; b++) if (m_stable[b]) m_code = 2'(b);
                    m_busy = 1'b1;
                end else if ($countones(m_stable[3:0]) > 1) begin
                    m_err  = 1'b1;
                    m_busy = 1'b1;
                end
            end else if (m_stable[3:0] == 4'd0) begin
                m_busy = 1'b0;
            end
            for (int j = int'(D) + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = {set, switch};
            // A level flips once the last D synchronised samples all disagree with it.
            for (int b = 0; b < 5; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int j = 2; j <= int'(D) + 1; j++) begin
                    if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
                end
                if (all_diff) m_stable[b] = ~m_stable[b];
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("set_pulse", 32'(set_pulse), 32'(m_set_pulse));
            chk("ans_valid", 32'(ans_valid), 32'(m_valid));
            chk("ans_code",  32'(ans_code),  32'(m_code));
            chk("multi_err", 32'(multi_err), 32'(m_err));
            chk("sw_stable", 32'(sw_stable), 32'(m_stable[3:0]));
        end
        n_valid += int'(ans_valid);
        n_err   += int'(multi_err);
        n_set   += int'(set_pulse);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_set_pulse"}, 32'(set_pulse), 32'd0);
        chk({tag, "_ans_valid"}, 32'(ans_valid), 32'd0);
        chk({tag, "_ans_code"},  32'(ans_code),  32'd0);
        chk({tag, "_multi_err"}, 32'(multi_err), 32'd0);
        chk({tag, "_sw_stable"}, 32'(sw_stable), 32'd0);
    endtask

    initial begin
        int v0;
        int e0;
        int s0;
        #1 reset = 1'b0;
        check_en = 1'b1;
        #1 chk_all_zero("por");
        tick(3);
        reset = 1'b1;
        tick(3);

        // Single press of switch[2]: stable on edge 6, accepted on edge 7.
        v0 = n_valid;
        switch = 4'b0100;
        tick(5);
        chk("press_sw_stable_e5", 32'(sw_stable), 32'd0);
        tick(1);
        chk("press_sw_stable_e6", 32'(sw_stable), 32'h4);
        chk("press_valid_e6", 32'(ans_valid), 32'd0);
        tick(1);
        chk("press_valid_e7", 32'(ans_valid), 32'd1);
        chk("press_code_e7", 32'(ans_code), 32'd2);
        tick(10);
        chk("press_one_pulse", 32'(n_valid - v0), 32'd1);
        switch = 4'b0000;
        tick(8);

        // Glitch of three cycles never reaches the debounced level.
        v0 = n_valid;
        switch = 4'b0001;
        tick(3);
        switch = 4'b0000;
        tick(10);
        chk("glitch_stable", 32'(sw_stable), 32'd0);
        chk("glitch_no_valid", 32'(n_valid - v0), 32'd0);

        // Simultaneous press of switch[1] and switch[3] is an error.
        v0 = n_valid;
        e0 = n_err;
        switch = 4'b1010;
        tick(8);
        chk("multi_err_count", 32'(n_err - e0), 32'd1);
        chk("multi_no_valid", 32'(n_valid - v0), 32'd0);
        chk("multi_code_kept", 32'(ans_code), 32'd2);
        switch = 4'b0000;
        tick(8);
        switch = 4'b1000;
        tick(8);
        chk("after_multi_valid", 32'(n_valid - v0), 32'd1);
        chk("after_multi_code", 32'(ans_code), 32'd3);
        switch = 4'b0000;
        tick(8);

        // Later presses during a hold are ignored until full release.
        v0 = n_valid;
        switch = 4'b0001;
        tick(8);
        switch = 4'b0011;
        tick(8);
        switch = 4'b0001;
        tick(8);
        switch = 4'b0000;
        tick(8);
        chk("hold_one_valid", 32'(n_valid - v0), 32'd1);
        chk("hold_code0", 32'(ans_code), 32'd0);
        switch = 4'b0010;
        tick(8);
        chk("rel_second_valid", 32'(n_valid - v0), 32'd2);
        chk("rel_code1", 32'(ans_code), 32'd1);
        switch = 4'b0000;
        tick(8);

        // Set and switch[2] together: both events on edge 7; held set pulses once.
        s0 = n_set;
        set = 1'b1;
        switch = 4'b0100;
        tick(7);
        chk("set_pulse_e7", 32'(set_pulse), 32'd1);
        chk("set_valid_e7", 32'(ans_valid), 32'd1);
        tick(50);
        chk("set_once", 32'(n_set - s0), 32'd1);
        set = 1'b0;
        switch = 4'b0000;
        tick(8);

        // Reset while held; re-accept on edge 7 after release.
        switch = 4'b0010;
        tick(10);
        reset = 1'b0;
        #1 chk_all_zero("rst");
        tick(3);
        chk_all_zero("rst_hold");
        reset = 1'b1;
        tick(6);
        chk("rst_valid_e6", 32'(ans_valid), 32'd0);
        tick(1);
        chk("rst_valid_e7", 32'(ans_valid), 32'd1);
        chk("rst_code_e7", 32'(ans_code), 32'd1);
        switch = 4'b0000;
        tick(8);

        // Randomized phase.
        for (int it = 0; it < 1500; it++) begin
            int r;
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b0;
                tick($urandom_range(1, 3));
                reset = 1'b1;
            end
            r = $urandom_range(0, 9);
            if (r <= 3) switch = 4'd0;
            else if (r <= 7) switch = 4'(1 << $urandom_range(0, 3));
            else if (r == 8) switch = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) set = ~set;
            tick($urandom_range(1, 10));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
